// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide unit that owns the HI/LO register pair.
// Handles one bit per clock, with a start/busy/done handshake toward decode.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 skip_q, skip_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_trial;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  assign signed_op = ~op[0];
  assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; trial subtract, restore on borrow.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_next  = div_trial[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q  ? -acc_q : acc_q;
  assign quot_fix = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    skip_d   = skip_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;

    unique case (state_q)
      IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          is_div_d = op[1];
          neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d   = signed_op & a[WIDTH-1];
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
          opnd_d   = op[1] ? abs_b : abs_a;
          if (op[1] && (b == '0)) begin
            dz_d    = 1'b1;
            skip_d  = 1'b1;
            state_d = FINISH;
          end else begin
            dz_d    = 1'b0;
            skip_d  = 1'b0;
            cnt_d   = CW'(WIDTH);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FINISH;
      end
      FINISH: begin
        if (!skip_q) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      skip_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      skip_q   <= skip_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start, mthi, mtlo;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wdata;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] m_hi, m_lo;
  logic         m_dz;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: full-width arithmetic on 64-bit integers.
  task automatic model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx, sy, sp;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'd0: begin sp = sx * sy; {m_hi, m_lo} = sp; m_dz = 1'b0; end
      2'd1: begin up = ux * uy; {m_hi, m_lo} = up; m_dz = 1'b0; end
      2'd2: begin
        if (y == 0) m_dz = 1'b1;
        else begin
          sp = sx / sy; m_lo = sp[W-1:0];
          sp = sx % sy; m_hi = sp[W-1:0];
          m_dz = 1'b0;
        end
      end
      default: begin
        if (y == 0) m_dz = 1'b1;
        else begin
          up = ux / uy; m_lo = up[W-1:0];
          up = ux % uy; m_hi = up[W-1:0];
          m_dz = 1'b0;
        end
      end
    endcase
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic do_op(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    int lat, bcnt, exp_lat;
    exp_lat = (o[1] && y == 0) ? 1 : W + 1;
    model_op(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = $urandom_range(0, 3); a = $urandom; b = $urandom;
    wait_done(lat, bcnt);
    check({nm, ".latency"}, lat, exp_lat);
    check({nm, ".busy_cycles"}, bcnt, exp_lat);
    check({nm, ".done"}, done, 1);
    check({nm, ".hi"}, hi, m_hi);
    check({nm, ".lo"}, lo, m_lo);
    check({nm, ".div_zero"}, div_zero, m_dz);
    @(posedge clk); #1;
    check({nm, ".done_width"}, done, 0);
  endtask

  task automatic mt_write(input string nm, input logic h, input logic l, input logic [W-1:0] d);
    @(negedge clk);
    mthi = h; mtlo = l; wdata = d;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
    check({nm, ".hi"}, hi, m_hi);
    check({nm, ".lo"}, lo, m_lo);
  endtask

  initial begin
    int lat, bcnt, ndone;

    vecs[0] = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[6] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7] = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8] = '{2'd0, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.div_zero", div_zero, 0);
    check("reset.hi", hi, 0);
    check("reset.lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d.tbl_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d.tbl_lo", i), lo, vecs[i].exp_lo);
    end

    // Preload, divide by zero, then recovery.
    mt_write("mt_both", 1'b1, 1'b1, 32'h12345678);
    do_op("div0", 2'd2, 32'd55, 32'd0);
    check("div0.hi_kept", hi, 32'h12345678);
    check("div0.lo_kept", lo, 32'h12345678);
    check("div0.sticky", div_zero, 1);
    do_op("after_div0", 2'd0, 32'd2, 32'd3);
    check("after_div0.lo", lo, 32'd6);
    check("after_div0.dz_clear", div_zero, 0);
    mt_write("mt_hi_only", 1'b1, 1'b0, 32'hCAFEF00D);
    mt_write("mt_lo_only", 1'b0, 1'b1, 32'h0BADBEEF);

    // start and mthi pulsed mid-operation must be ignored.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      start = (e == 10); mthi = (e == 10); op = 2'd3; wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0;
      if (done) begin lat = e; break; end
    end
    check("busy_ignore.latency", lat, W + 1);
    check("busy_ignore.lo", lo, 32'h0000003F);
    check("busy_ignore.hi", hi, 32'h00000000);
    @(posedge clk); #1;
    check("busy_ignore.no_second", busy, 0);
    m_hi = hi; m_lo = lo;

    // start and mthi at the same idle edge: MT lands first, result overwrites.
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4; mthi = 1'b1; wdata = 32'h0000FFFF;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check("mt_start.hi_landed", hi, 32'h0000FFFF);
    wait_done(lat, bcnt);
    check("mt_start.hi", hi, 32'd0);
    check("mt_start.lo", lo, 32'd12);
    m_hi = hi; m_lo = lo;

    // Reset mid-operation.
    mt_write("pre_rst", 1'b1, 1'b1, 32'hAAAA5555);
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'hFFFF0000; b = 32'h00010001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.busy", busy, 0);
    check("rst_mid.done", done, 0);
    check("rst_mid.hi", hi, 0);
    check("rst_mid.lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("rst_mid.no_done", ndone, 0);
    do_op("after_rst", 2'd1, 32'h00001000, 32'h00100000);

    // Random operations with occasional MT writes and zero divisors.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] rx, ry;
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) ry = {24'd0, 8'($urandom)};
      if ($urandom_range(0, 4) == 0)
        mt_write($sformatf("rnd%0d.mt", i), 1'($urandom), 1'($urandom), $urandom);
      do_op($sformatf("rnd%0d", i), ro, rx, ry);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
